// File: rtl/cu_cmd_loader.sv
// -----------------------------------------------------------------------------
// cu_cmd_loader
//
// Command front-end for the combinational complex-arithmetic unit (CU).
// Collects one complex operation as four 16-bit words (re1, im1, re2, im2)
// plus a 2-bit opcode over a valid/ready stream, holds them on the CU operand
// inputs, waits SETTLE_CYCLES for the CU to settle, then captures the CU
// results and offers them on a valid/ready result port. One operation is in
// flight at a time; no new word is accepted until the result is consumed.
//
// Parameters:
//   SETTLE_CYCLES  cycles from the last operand edge to result capture (1..15)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          command word handshake
//   in_data[15:0]              operand word (re1, im1, re2, im2 in order)
//   in_task[1:0]               opcode, sampled with word 0 only
//   cu_re1..cu_im2, cu_task    registered operands/opcode driven to the CU
//   cu_out_re, cu_out_im       CU results
//   res_valid/res_ready        result handshake
//   res_re, res_im             captured result (zeroed on divide-by-zero)
//   res_task                   opcode of the captured result
//   res_dz                     divide-by-zero flag
// -----------------------------------------------------------------------------
module cu_cmd_loader #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [1:0]  in_task,

    output logic [15:0] cu_re1,
    output logic [15:0] cu_im1,
    output logic [15:0] cu_re2,
    output logic [15:0] cu_im2,
    output logic [1:0]  cu_task,
    input  logic [31:0] cu_out_re,
    input  logic [31:0] cu_out_im,

    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_re,
    output logic [31:0] res_im,
    output logic [1:0]  res_task,
    output logic        res_dz
);

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_OUT    = 2'd2;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    logic [1:0]  state_q,      state_d;
    logic [1:0]  word_cnt_q,   word_cnt_d;
    logic [3:0]  settle_cnt_q, settle_cnt_d;

    logic [15:0] cu_re1_q,  cu_re1_d;
    logic [15:0] cu_im1_q,  cu_im1_d;
    logic [15:0] cu_re2_q,  cu_re2_d;
    logic [15:0] cu_im2_q,  cu_im2_d;
    logic [1:0]  cu_task_q, cu_task_d;

    logic        res_valid_q, res_valid_d;
    logic [31:0] res_re_q,    res_re_d;
    logic [31:0] res_im_q,    res_im_d;
    logic [1:0]  res_task_q,  res_task_d;
    logic        res_dz_q,    res_dz_d;

    logic        accept;
    logic        div_by_zero;

    // Ready is a pure state decode so the source never sees a combinational
    // path from its own valid back to ready.
    assign in_ready = (state_q == ST_LOAD);
    assign accept   = in_valid & in_ready;

    // Evaluated on the registered operands, which are stable during SETTLE.
    assign div_by_zero = (cu_task_q == 2'd3) && (cu_re2_q == '0) && (cu_im2_q == '0);

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        settle_cnt_d = settle_cnt_q;
        cu_re1_d     = cu_re1_q;
        cu_im1_d     = cu_im1_q;
        cu_re2_d     = cu_re2_q;
        cu_im2_d     = cu_im2_q;
        cu_task_d    = cu_task_q;
        res_valid_d  = res_valid_q;
        res_re_d     = res_re_q;
        res_im_d     = res_im_q;
        res_task_d   = res_task_q;
        res_dz_d     = res_dz_q;

        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    // Two-bit counter wraps to 0 on its own after word 3.
                    word_cnt_d = word_cnt_q + 2'd1;
                    case (word_cnt_q)
                        2'd0: begin
                            cu_re1_d  = in_data;
                            cu_task_d = in_task;
                        end
                        2'd1: cu_im1_d = in_data;
                        2'd2: cu_re2_d = in_data;
                        default: begin
                            cu_im2_d     = in_data;
                            settle_cnt_d = SETTLE_INIT;
                            state_d      = ST_SETTLE;
                        end
                    endcase
                end
            end

            ST_SETTLE: begin
                if (settle_cnt_q == '0) begin
                    res_valid_d = 1'b1;
                    res_task_d  = cu_task_q;
                    res_dz_d    = div_by_zero;
                    res_re_d    = div_by_zero ? '0 : cu_out_re;
                    res_im_d    = div_by_zero ? '0 : cu_out_im;
                    state_d     = ST_OUT;
                end else begin
                    settle_cnt_d = settle_cnt_q - 4'd1;
                end
            end

            ST_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_LOAD;
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            word_cnt_q   <= '0;
            settle_cnt_q <= '0;
            cu_re1_q     <= '0;
            cu_im1_q     <= '0;
            cu_re2_q     <= '0;
            cu_im2_q     <= '0;
            cu_task_q    <= '0;
            res_valid_q  <= 1'b0;
            res_re_q     <= '0;
            res_im_q     <= '0;
            res_task_q   <= '0;
            res_dz_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            cu_re1_q     <= cu_re1_d;
            cu_im1_q     <= cu_im1_d;
            cu_re2_q     <= cu_re2_d;
            cu_im2_q     <= cu_im2_d;
            cu_task_q    <= cu_task_d;
            res_valid_q  <= res_valid_d;
            res_re_q     <= res_re_d;
            res_im_q     <= res_im_d;
            res_task_q   <= res_task_d;
            res_dz_q     <= res_dz_d;
        end
    end

    assign cu_re1    = cu_re1_q;
    assign cu_im1    = cu_im1_q;
    assign cu_re2    = cu_re2_q;
    assign cu_im2    = cu_im2_q;
    assign cu_task   = cu_task_q;
    assign res_valid = res_valid_q;
    assign res_re    = res_re_q;
    assign res_im    = res_im_q;
    assign res_task  = res_task_q;
    assign res_dz    = res_dz_q;

endmodule

// File: tb/tb_cu_cmd_loader.sv
// -----------------------------------------------------------------------------
// tb_cu_cmd_loader
//
// Two loader instances (SETTLE_CYCLES = 1 and 3), each driving a behavioural
// CU model. Directed commands from the test plan are followed by randomized
// commands whose expected results come from a plain-arithmetic reference of
// the complex operations.
// -----------------------------------------------------------------------------
module tb_cu_cmd_loader;

    logic clk;
    logic rst_n;

    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [15:0] in_data   [2];
    logic [1:0]  in_task   [2];
    logic [15:0] cu_re1    [2];
    logic [15:0] cu_im1    [2];
    logic [15:0] cu_re2    [2];
    logic [15:0] cu_im2    [2];
    logic [1:0]  cu_task   [2];
    logic [31:0] cu_out_re [2];
    logic [31:0] cu_out_im [2];
    logic        res_valid [2];
    logic        res_ready [2];
    logic [31:0] res_re    [2];
    logic [31:0] res_im    [2];
    logic [1:0]  res_task  [2];
    logic        res_dz    [2];

    int settle_of [2] = '{1, 3};
    int n_checks = 0;
    int n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cu_cmd_loader #(.SETTLE_CYCLES(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_task(in_task[0]),
        .cu_re1(cu_re1[0]), .cu_im1(cu_im1[0]), .cu_re2(cu_re2[0]), .cu_im2(cu_im2[0]),
        .cu_task(cu_task[0]), .cu_out_re(cu_out_re[0]), .cu_out_im(cu_out_im[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]),
        .res_re(res_re[0]), .res_im(res_im[0]), .res_task(res_task[0]), .res_dz(res_dz[0])
    );

    cu_cmd_loader #(.SETTLE_CYCLES(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_task(in_task[1]),
        .cu_re1(cu_re1[1]), .cu_im1(cu_im1[1]), .cu_re2(cu_re2[1]), .cu_im2(cu_im2[1]),
        .cu_task(cu_task[1]), .cu_out_re(cu_out_re[1]), .cu_out_im(cu_out_im[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]),
        .res_re(res_re[1]), .res_im(res_im[1]), .res_task(res_task[1]), .res_dz(res_dz[1])
    );

    // Complex arithmetic on signed 16-bit parts, truncated to 32-bit results.
    // A zero divisor yields junk that the loader is expected to mask.
    function automatic logic [63:0] cu_model(input logic [1:0] t, input logic [15:0] a,
                                             input logic [15:0] b, input logic [15:0] c,
                                             input logic [15:0] e);
        longint ar, ai, br, bi, re, im, den;
        ar = longint'($signed(a));
        ai = longint'($signed(b));
        br = longint'($signed(c));
        bi = longint'($signed(e));
        case (t)
            2'd0: begin re = ar + br; im = ai + bi; end
            2'd1: begin re = ar - br; im = ai - bi; end
            2'd2: begin re = ar * br - ai * bi; im = ar * bi + ai * br; end
            default: begin
                den = br * br + bi * bi;
                if (den == 0) begin
                    re = 64'h0000_0000_DEAD_BEEF;
                    im = 64'h0000_0000_BADC_0FFE;
                end else begin
                    re = (ar * br + ai * bi) / den;
                    im = (ai * br - ar * bi) / den;
                end
            end
        endcase
        return {re[31:0], im[31:0]};
    endfunction

    assign {cu_out_re[0], cu_out_im[0]} = cu_model(cu_task[0], cu_re1[0], cu_im1[0], cu_re2[0], cu_im2[0]);
    assign {cu_out_re[1], cu_out_im[1]} = cu_model(cu_task[1], cu_re1[1], cu_im1[1], cu_re2[1], cu_im2[1]);

    // Expected {re, im} for a command as sent: zero on divide-by-zero.
    function automatic logic [63:0] ref_result(input logic [1:0] t, input logic [3:0][15:0] w);
        if (t == 2'd3 && w[2] == 16'd0 && w[3] == 16'd0)
            return '0;
        return cu_model(t, w[0], w[1], w[2], w[3]);
    endfunction

    function automatic logic [3:0][15:0] mk(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c, input logic [15:0] e);
        logic [3:0][15:0] w;
        w[0] = a; w[1] = b; w[2] = c; w[3] = e;
        return w;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input int d);
        check("rst_in_ready", 128'(in_ready[d]), 128'(1));
        check("rst_cu", 128'({cu_re1[d], cu_im1[d], cu_re2[d], cu_im2[d], cu_task[d]}), 128'(0));
        check("rst_res", 128'({res_valid[d], res_re[d], res_im[d], res_task[d], res_dz[d]}), 128'(0));
    endtask

    // Full command: gap idle cycles before each of words 1..3, bp cycles of
    // result backpressure (with a new word held on the input), then handshake.
    task automatic run_cmd(input int d, input logic [1:0] t, input logic [3:0][15:0] w,
                           input int gap, input int bp, input logic [63:0] exp_res,
                           input logic exp_dz);
        int n;
        logic [15:0] got;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                in_valid[d] = 1'b0;
                in_data[d]  = $urandom;
                repeat (gap) step();
            end
            in_valid[d] = 1'b1;
            in_data[d]  = w[i];
            in_task[d]  = (i == 0) ? t : ~t;
            check("word_ready", 128'(in_ready[d]), 128'(1));
            step();
            case (i)
                0: got = cu_re1[d];
                1: got = cu_im1[d];
                2: got = cu_re2[d];
                default: got = cu_im2[d];
            endcase
            check("word_reg", 128'(got), 128'(w[i]));
            if (i == 0) check("task_reg", 128'(cu_task[d]), 128'(t));
        end
        in_valid[d] = 1'b0;
        in_task[d]  = $urandom;
        n = 0;
        while (res_valid[d] !== 1'b1 && n < 40) begin
            check("settle_hold", 128'({cu_re1[d], cu_im1[d], cu_re2[d], cu_im2[d], cu_task[d], in_ready[d]}),
                  128'({w[0], w[1], w[2], w[3], t, 1'b0}));
            step();
            n++;
        end
        check("latency", 128'(n), 128'(settle_of[d]));
        check("res_re", 128'(res_re[d]), 128'(exp_res[63:32]));
        check("res_im", 128'(res_im[d]), 128'(exp_res[31:0]));
        check("res_task", 128'(res_task[d]), 128'(t));
        check("res_dz", 128'(res_dz[d]), 128'(exp_dz));
        res_ready[d] = 1'b0;
        in_valid[d]  = 1'b1;
        in_data[d]   = $urandom;
        for (int k = 0; k < bp; k++) begin
            step();
            check("bp_hold", 128'({res_valid[d], in_ready[d], res_re[d], res_im[d], res_task[d], res_dz[d]}),
                  128'({1'b1, 1'b0, exp_res, t, exp_dz}));
        end
        res_ready[d] = 1'b1;
        step();
        res_ready[d] = 1'b0;
        in_valid[d]  = 1'b0;
        check("post_hs", 128'({res_valid[d], in_ready[d], cu_re1[d]}), 128'({1'b0, 1'b1, w[0]}));
    endtask

    initial begin
        logic [3:0][15:0] w;
        logic [1:0] t;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            in_task[d]   = '0;
            res_ready[d] = 1'b0;
        end
        #3;
        check_reset(0);
        check_reset(1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Directed: SUM, MUL, DIV, DIV by zero on SETTLE_CYCLES=1
        run_cmd(0, 2'd0, mk(16'd3, 16'd4, 16'd1, 16'd2), 0, 0, {32'd4, 32'd6}, 1'b0);
        run_cmd(0, 2'd2, mk(16'd3, 16'd4, 16'd1, 16'd2), 0, 3, {32'hFFFF_FFFB, 32'd10}, 1'b0);
        run_cmd(0, 2'd3, mk(16'd10, 16'd5, 16'd2, 16'd1), 0, 1, {32'd5, 32'd0}, 1'b0);
        run_cmd(0, 2'd3, mk(16'd7, 16'd1, 16'd0, 16'd0), 0, 0, 64'd0, 1'b1);

        // Directed: stalled source on SETTLE_CYCLES=3
        run_cmd(1, 2'd1, mk(16'd20, 16'd30, 16'd5, 16'd7), 2, 3, {32'd15, 32'd23}, 1'b0);

        // Randomized commands on both instances
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 12; c++) begin
                t = 2'($urandom_range(0, 3));
                w = mk(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
                if (t == 2'd3 && $urandom_range(0, 3) == 0) begin
                    w[2] = '0;
                    w[3] = '0;
                end
                run_cmd(d, t, w, $urandom_range(0, 2), $urandom_range(0, 3), ref_result(t, w),
                        (t == 2'd3 && w[2] == 16'd0 && w[3] == 16'd0));
            end
        end

        // Reset mid-load: two words in, reset between edges, then a clean SUB
        in_valid[0] = 1'b1;
        in_task[0]  = 2'd2;
        in_data[0]  = 16'd100;
        step();
        in_data[0]  = 16'd200;
        step();
        in_valid[0] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset(0);
        check_reset(1);
        #1;
        rst_n = 1'b1;
        step();
        run_cmd(0, 2'd1, mk(16'd9, 16'd9, 16'd4, 16'd2), 0, 0, {32'd5, 32'd7}, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cu_cmd_loader.md
# cu_cmd_loader

Command front-end for the combinational complex-arithmetic unit (CU). It accepts one complex operation as four 16-bit words plus a 2-bit opcode over a valid/ready stream and holds them stable on the CU operand inputs. After a fixed settle time it captures the CU's 32-bit results and presents them on a valid/ready result port. It is the single sequential stage between the command source and the CU, and it serialises operations one at a time.

## Interface
Parameters:
- SETTLE_CYCLES, default 1: cycles between the last operand being registered and the CU result being captured; legal range 1..15.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  command word valid.
- in_ready  out  1  loader can accept a word.
- in_data  in  16  operand word; order is re1, im1, re2, im2.
- in_task  in  2  opcode (0 SUM, 1 SUB, 2 MUL, 3 DIV); sampled with word 0 only.
- cu_re1, cu_im1, cu_re2, cu_im2  out  16 each  registered operands driven to the CU.
- cu_task  out  2  registered opcode driven to the CU.
- cu_out_re, cu_out_im  in  32 each  CU results.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_re, res_im  out  32 each  captured result.
- res_task  out  2  opcode of the captured result.
- res_dz  out  1  divide-by-zero flag for the captured result.

## Operation
- FSM states: LOAD, SETTLE, OUT. Reset state is LOAD with word counter = 0.
- LOAD:
  - in_ready = 1.
  - Each accepted word (in_valid & in_ready) is written into the operand register selected by the 2-bit word counter, and the counter increments.
  - On word 0, in_task is also registered into cu_task.
  - Accepting word 3 wraps the counter to 0, loads the settle counter with SETTLE_CYCLES−1, and moves the FSM to SETTLE.
- SETTLE:
  - in_ready = 0; cu_* outputs are held.
  - The settle counter decrements each cycle.
  - In the cycle the counter equals 0, the block captures the results and moves to OUT:
    - res_re/res_im ← cu_out_re/cu_out_im, taken unmodified with full 32 bits.
    - res_task ← cu_task.
    - res_dz ← (cu_task == 3) & (cu_re2 == 0) & (cu_im2 == 0).
    - When res_dz is 1, res_re and res_im are forced to 0 instead of the CU outputs.
- OUT:
  - res_valid = 1 and in_ready = 0.
  - All res_* outputs hold until res_valid & res_ready.
  - On that handshake, res_valid drops and the FSM returns to LOAD.
  - cu_* outputs keep their last values until overwritten by the next command.
- No overlap between commands: words presented while in SETTLE or OUT are not accepted, and the source must hold them.
- in_valid deasserting mid-command pauses loading. There is no timeout, and the partial command is kept.
- Reset, asynchronous at any time including mid-load:
  - All outputs go to 0 except in_ready, which is 1 (LOAD).
  - Counters clear and any partial or pending command is discarded.

## Timing
- in_ready is a combinational decode of the state (1 only in LOAD) and does not depend on in_valid.
- Each cu_* register updates on the same edge that accepts its word.
- Latency: if word 3 is accepted at edge t, capture occurs at edge t+SETTLE_CYCLES, and res_valid is high from that edge.
- Minimum command-to-command period is 4 + SETTLE_CYCLES + 1 cycles when res_ready is held high.
- res_valid falls on the edge after the handshake, and in_ready rises on that same edge.
- Reset values:
  - res_valid, res_re, res_im, res_task, res_dz, cu_re1, cu_im1, cu_re2, cu_im2 and cu_task are all 0.
  - in_ready is 1.

## Test plan
- SUM, SETTLE_CYCLES=1:
  - Stimulus: words 3, 4, 1, 2 with in_task=0, back-to-back.
  - Response: res_valid exactly 1 cycle after word 3 is accepted; res_re=4, res_im=6, res_task=0, res_dz=0.
- MUL:
  - Stimulus: (3+4i)·(1+2i).
  - Response: res_re=32'hFFFFFFFB, res_im=10; cu_* stay stable throughout SETTLE.
- DIV:
  - Stimulus: (10+5i)/(2+1i), then (7+1i)/(0+0i).
  - Response: first result res_re=5, res_im=0, res_dz=0; second result res_dz=1, res_re=0, res_im=0.
- Backpressure:
  - Stimulus: hold res_ready=0 for 3 cycles after res_valid rises, and keep in_valid=1 with a new word on in_data.
  - Response: res_* stay constant and in_ready=0 throughout; the new word is accepted only on the cycle after the handshake.
- Stalled source, SETTLE_CYCLES=3:
  - Stimulus: insert in_valid gaps between words.
  - Response: word order is preserved; res_valid rises 3 cycles after word 3 is accepted.
- Reset mid-load:
  - Stimulus: load 2 words, pulse rst_n low between edges, then send a full SUB command 9, 9, 4, 2.
  - Response: all outputs read 0 and in_ready=1 during reset; the result is res_re=5, res_im=7 with no stale words used.
